// File: rtl/mem_stream_reader_if.sv
// RAM-port and output-stream signal bundle for mem_stream_reader.
// The o_tlast member exists only when MEM_STREAM_READER_TLAST_EN is defined.
interface mem_stream_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [3:0]            o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_din;
  logic [DATA_WIDTH-1:0] i_mem_dout;
  logic                  o_tvalid;
  logic [DATA_WIDTH-1:0] o_tdata;
  logic                  i_tready;
`ifdef MEM_STREAM_READER_TLAST_EN
  logic                  o_tlast;
`endif

  modport master (
    output o_mem_we, o_mem_addr, o_mem_din, o_tvalid, o_tdata,
`ifdef MEM_STREAM_READER_TLAST_EN
    o_tlast,
`endif
    input  i_mem_dout, i_tready
  );

  modport slave (
    input  o_mem_we, o_mem_addr, o_mem_din, o_tvalid, o_tdata,
`ifdef MEM_STREAM_READER_TLAST_EN
    o_tlast,
`endif
    output i_mem_dout, i_tready
  );
endinterface

// File: rtl/mem_stream_reader.sv
// Streams a contiguous run of RAM words out through a 4-entry credit-managed FIFO.
// Optional last-word marker enabled by defining MEM_STREAM_READER_TLAST_EN.
module mem_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_len,
  output logic                  o_busy,
  output logic                  o_done,
  mem_stream_reader_if.master   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int                  FIFO_DEPTH = 4;
  localparam logic [ADDR_WIDTH:0]   ONE_CNT  = 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = 1;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_issued_cnt;
  logic [ADDR_WIDTH:0]   r_sent_cnt;
  logic                  r_rd_pending;
  logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [2:0]            r_count;
`ifdef MEM_STREAM_READER_TLAST_EN
  logic [FIFO_DEPTH-1:0] r_tag;
`endif

  logic       w_tvalid;
  logic       w_push;
  logic       w_pop;
  logic       w_issue;
  logic [3:0] w_credit;

  // Credit counts words already buffered plus the one still in the RAM pipeline.
  assign w_tvalid = (r_count != 3'd0);
  assign w_pop    = w_tvalid & bus.i_tready;
  assign w_push   = r_rd_pending;
  assign w_credit = {1'b0, r_count} + {3'b000, r_rd_pending};
  assign w_issue  = (r_state == RUN) && (r_issued_cnt < r_len) && (w_credit < 4'd4);

  assign bus.o_mem_we   = 4'b0000;
  assign bus.o_mem_din  = '0;
  assign bus.o_mem_addr = r_mem_addr;
  assign bus.o_tvalid   = w_tvalid;
  assign bus.o_tdata    = r_fifo[r_rd_ptr];
`ifdef MEM_STREAM_READER_TLAST_EN
  assign bus.o_tlast    = w_tvalid & r_tag[r_rd_ptr];
`endif
  assign o_busy = r_busy;
  assign o_done = r_done;

  // NOTE: every register here uses <= so all updates see pre-edge values,
  // which is what makes push, pop and credit checks in one cycle consistent.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mem_addr   <= '0;
      r_len        <= '0;
      r_issued_cnt <= '0;
      r_sent_cnt   <= '0;
      r_rd_pending <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      // NOTE: the FIFO storage is only four words and its head drives o_tdata
      // directly, so it is cleared to give a defined zero output after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
`ifdef MEM_STREAM_READER_TLAST_EN
      r_tag        <= '0;
`endif
    end else begin
      r_done       <= 1'b0;
      r_rd_pending <= w_issue;

      if (w_issue) begin
        r_mem_addr   <= r_mem_addr + ONE_ADDR;
        r_issued_cnt <= r_issued_cnt + ONE_CNT;
      end

      if (w_push) begin
        r_fifo[r_wr_ptr] <= bus.i_mem_dout;
`ifdef MEM_STREAM_READER_TLAST_EN
        // The last word's data arrives exactly when every read has been issued.
        r_tag[r_wr_ptr]  <= (r_issued_cnt == r_len);
`endif
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_len != '0) begin
              r_mem_addr   <= i_base_addr;
              r_len        <= i_len;
              r_issued_cnt <= '0;
              r_sent_cnt   <= '0;
              r_busy       <= 1'b1;
              r_state      <= RUN;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        RUN: begin
          if (w_pop) begin
            r_sent_cnt <= r_sent_cnt + ONE_CNT;
            if (r_sent_cnt == r_len - ONE_CNT) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a behavioural 1-cycle-latency RAM.
// Define MEM_STREAM_READER_TLAST_EN to also exercise the o_tlast marker.
module tb_mem_stream_reader;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          busy;
  logic          done;

  mem_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_base_addr(base),
    .i_len(len), .o_busy(busy), .o_done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk) bus.i_mem_dout <= mem[bus.o_mem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] got_d [$];
  logic          got_l [$];
  int            got_c [$];
  int            first_v, done_cyc;
  logic          done_busy;
  logic [AW-1:0] probe_addr;
  logic [DW-1:0] probe_data;
  logic          probe_valid, probe_last;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_cmd(input logic [AW-1:0] b, input logic [AW:0] l);
    start = 1'b1; base = b; len = l;
    step();
    start = 1'b0;
  endtask

  // Runs cycles 1..max_c after the start cycle, recording handshakes; stalls
  // i_tready over [s_lo,s_hi], probes at probe_c, re-strobes start at restart_c.
  task automatic collect(input int max_c, input int s_lo, input int s_hi,
                         input int probe_c, input int restart_c);
    got_d.delete(); got_l.delete(); got_c.delete();
    first_v = -1; done_cyc = -1; done_busy = 1'bx;
    for (int c = 1; c <= max_c; c++) begin
      start = (c == restart_c);
      if (c == restart_c) begin base = 10'd0; len = 11'd5; end
      bus.i_tready = !(c >= s_lo && c <= s_hi);
      if (bus.o_tvalid && first_v < 0) first_v = c;
      if (c == probe_c) begin
        probe_addr = bus.o_mem_addr; probe_data = bus.o_tdata; probe_valid = bus.o_tvalid;
`ifdef MEM_STREAM_READER_TLAST_EN
        probe_last = bus.o_tlast;
`else
        probe_last = 1'b0;
`endif
      end
      if (bus.o_tvalid && bus.i_tready) begin
        got_d.push_back(bus.o_tdata); got_c.push_back(c);
`ifdef MEM_STREAM_READER_TLAST_EN
        got_l.push_back(bus.o_tlast);
`else
        got_l.push_back(1'b0);
`endif
      end
      if (done) begin
        done_cyc = c; done_busy = busy;
        break;
      end
      step();
    end
    start = 1'b0;
    bus.i_tready = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(); step();
    n_cmp++;
    if ({busy, done, bus.o_tvalid, bus.o_tdata, bus.o_mem_addr, bus.o_mem_we, bus.o_mem_din}
        !== {3'b000, 32'h0, 10'h0, 4'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_outputs: busy=%b done=%b tvalid=%b tdata=%h addr=%h we=%h din=%h, required all 0",
               busy, done, bus.o_tvalid, bus.o_tdata, bus.o_mem_addr, bus.o_mem_we, bus.o_mem_din);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_d [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    for (int i = 0; i < 4; i++) mem[i] = exp_d[i];
    start_cmd(10'd0, 11'd4);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b required 1", busy); end
    collect(30, 0, -1, 0, 0);
    n_cmp++;
    if (first_v !== 3) begin n_bad++; $display("FAIL basic_first_valid: cycle %0d required 3", first_v); end
    n_cmp++;
    if (got_d.size() !== 4) begin
      n_bad++; $display("FAIL basic_count: got %0d words required 4", got_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got_d[i] !== exp_d[i] || got_c[i] !== 3 + i || got_l[i] !== 1'b0
`ifdef MEM_STREAM_READER_TLAST_EN
            && i < 3 || (i == 3 && got_l[i] !== 1'b1)
`endif
           ) begin
          n_bad++;
          $display("FAIL basic_word%0d: got %h@%0d last=%b required %h@%0d", i, got_d[i], got_c[i],
                   got_l[i], exp_d[i], 3 + i);
        end
      end
    end
    n_cmp++;
    if (done_cyc !== 7 || done_busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_done: cycle %0d busy=%b required cycle 7 busy=0", done_cyc, done_busy);
    end
    step();
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b required 0", done); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) mem[i] = 32'hA0 + i;
    start_cmd(10'd0, 11'd8);
    collect(40, 3, 8, 8, 0);
    n_cmp++;
    if (probe_valid !== 1'b1 || probe_data !== 32'hA0) begin
      n_bad++; $display("FAIL bp_hold: tvalid=%b tdata=%h required 1 / a0", probe_valid, probe_data);
    end
    n_cmp++;
    if (probe_addr !== 10'd4) begin
      n_bad++; $display("FAIL bp_reads_stop: addr=%0d required 4", probe_addr);
    end
    n_cmp++;
    if (got_d.size() !== 8) begin
      n_bad++; $display("FAIL bp_count: got %0d words required 8", got_d.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (got_d[i] !== 32'hA0 + i || got_c[i] !== 9 + i) begin
          n_bad++;
          $display("FAIL bp_word%0d: got %h@%0d required %h@%0d", i, got_d[i], got_c[i], 32'hA0 + i, 9 + i);
        end
      end
    end
    n_cmp++;
    if (done_cyc !== 17) begin n_bad++; $display("FAIL bp_done: cycle %0d required 17", done_cyc); end
    step();
  endtask

  task automatic test_wrap();
    mem[1022] = 32'h11; mem[1023] = 32'h22; mem[0] = 32'h33;
    start_cmd(10'd1022, 11'd3);
    collect(30, 0, -1, 0, 0);
    n_cmp++;
    if (got_d.size() !== 3 || got_d[0] !== 32'h11 || got_d[1] !== 32'h22 || got_d[2] !== 32'h33) begin
      n_bad++;
      $display("FAIL wrap_data: got %0d words [%h %h %h] required [11 22 33]", got_d.size(),
               got_d.size() > 0 ? got_d[0] : 32'hx, got_d.size() > 1 ? got_d[1] : 32'hx,
               got_d.size() > 2 ? got_d[2] : 32'hx);
    end
    n_cmp++;
    if (done_cyc !== 6) begin n_bad++; $display("FAIL wrap_done: cycle %0d required 6", done_cyc); end
    step();
  endtask

  task automatic test_zero_len();
    start_cmd(10'd5, 11'd0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.o_tvalid !== 1'b0) begin
      n_bad++; $display("FAIL zero_len_done: done=%b busy=%b tvalid=%b required 1 0 0", done, busy, bus.o_tvalid);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || bus.o_tvalid !== 1'b0) begin
      n_bad++; $display("FAIL zero_len_after: done=%b busy=%b tvalid=%b required 0 0 0", done, busy, bus.o_tvalid);
    end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 8; i++) mem[i] = 32'hA0 + i;
    start_cmd(10'd4, 11'd3);
    collect(30, 0, -1, 0, 2);
    n_cmp++;
    if (got_d.size() !== 3 || got_d[0] !== 32'hA4 || got_d[1] !== 32'hA5 || got_d[2] !== 32'hA6) begin
      n_bad++; $display("FAIL ignore_data: got %0d words required 3 words a4..a6", got_d.size());
    end
    n_cmp++;
    if (done_cyc !== 6) begin n_bad++; $display("FAIL ignore_done: cycle %0d required 6", done_cyc); end
    step(); step(); step();
    n_cmp++;
    if (busy !== 1'b0 || bus.o_tvalid !== 1'b0) begin
      n_bad++; $display("FAIL ignore_idle: busy=%b tvalid=%b required 0 0", busy, bus.o_tvalid);
    end
  endtask

  task automatic test_reset_mid_run();
    int n_done = 0;
    for (int i = 0; i < 8; i++) mem[i] = 32'hA0 + i;
    start_cmd(10'd0, 11'd8);
    collect(4, 0, -1, 0, 0);
    n_cmp++;
    if (got_d.size() !== 2 || done_cyc !== -1) begin
      n_bad++; $display("FAIL abort_pre: got %0d words done@%0d required 2 words no done", got_d.size(), done_cyc);
    end
    rstn = 1'b0;
    step();
    n_cmp++;
    if ({busy, done, bus.o_tvalid, bus.o_tdata, bus.o_mem_addr} !== {3'b000, 32'h0, 10'h0}) begin
      n_bad++;
      $display("FAIL abort_outputs: busy=%b done=%b tvalid=%b tdata=%h addr=%h required all 0",
               busy, done, bus.o_tvalid, bus.o_tdata, bus.o_mem_addr);
    end
`ifdef MEM_STREAM_READER_TLAST_EN
    n_cmp++;
    if (bus.o_tlast !== 1'b0) begin n_bad++; $display("FAIL abort_tlast: got %b required 0", bus.o_tlast); end
`endif
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (done || bus.o_tvalid) n_done++;
      step();
    end
    n_cmp++;
    if (n_done !== 0) begin n_bad++; $display("FAIL abort_quiet: %0d active cycles required 0", n_done); end
    start_cmd(10'd0, 11'd2);
    collect(30, 0, -1, 0, 0);
    n_cmp++;
    if (got_d.size() !== 2 || got_d[0] !== 32'hA0 || got_d[1] !== 32'hA1 || got_c[0] !== 3 || done_cyc !== 5) begin
      n_bad++; $display("FAIL abort_restart: got %0d words done@%0d required a0,a1 from cycle 3 done@5",
                        got_d.size(), done_cyc);
    end
    step();
  endtask

`ifdef MEM_STREAM_READER_TLAST_EN
  task automatic test_tlast();
    for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + i;
    start_cmd(10'd0, 11'd3);
    collect(30, 5, 7, 6, 0);
    n_cmp++;
    if (probe_valid !== 1'b1 || probe_last !== 1'b1 || probe_data !== 32'hA2) begin
      n_bad++; $display("FAIL tlast_hold: tvalid=%b tlast=%b tdata=%h required 1 1 a2",
                        probe_valid, probe_last, probe_data);
    end
    n_cmp++;
    if (got_l.size() !== 3 || got_l[0] !== 1'b0 || got_l[1] !== 1'b0 || got_l[2] !== 1'b1 || got_c[2] !== 8) begin
      n_bad++; $display("FAIL tlast_pattern: %0d words, last flags wrong or word 3 not at cycle 8", got_l.size());
    end
    step();
  endtask
`endif

  initial begin
    start = 1'b0; base = '0; len = '0; rstn = 1'b0; bus.i_tready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_start_ignored();
    test_reset_mid_run();
`ifdef MEM_STREAM_READER_TLAST_EN
    test_tlast();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
- Read-side initiator for the team's dual-port block RAM, driving one RAM port. That port has a registered read with 1-cycle latency and a 4-bit write enable.
- On a start command, reads a contiguous run of words from a base address. Streams them out on a valid/ready interface toward the conv2d datapath.
- Absorbs RAM read latency and downstream backpressure with a 4-entry output FIFO, so no word is ever lost.

Parameters:
- DATA_WIDTH, 32, word width; matches the RAM data width.
- ADDR_WIDTH, 10, RAM address width; RAM depth is 2**ADDR_WIDTH.

Ports:
- i_clk  input  1  clock; single clock domain.
- i_rstn  input  1  reset; synchronous, active-low.
- i_start  input  1  command strobe; sampled only in IDLE.
- i_base_addr  input  ADDR_WIDTH  first word address; captured with i_start.
- i_len  input  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH; captured with i_start.
- o_busy  output  1  high from the cycle after start acceptance until the done pulse.
- o_done  output  1  1-cycle pulse when the last word has been handshaken out.
- o_mem_we  output  4  RAM write enable; constant 4'b0000.
- o_mem_addr  output  ADDR_WIDTH  RAM address, registered.
- o_mem_din  output  DATA_WIDTH  RAM write data; constant 0.
- i_mem_dout  input  DATA_WIDTH  RAM read data; valid the cycle after the address is presented.
- o_tvalid  output  1  stream data valid.
- o_tdata  output  DATA_WIDTH  stream data.
- i_tready  input  1  downstream ready.
- o_tlast  output  1  last-word marker; present only with the optional feature.

Behaviour:
- Reset: while i_rstn=0 at a clock edge, the following are cleared:
  - state returns to IDLE;
  - o_busy=0, o_done=0, o_tvalid=0, o_tdata=0, o_mem_addr=0, o_tlast=0;
  - FIFO is emptied and the issue and receive counters are zeroed;
  - any in-flight read is discarded.
  Reset mid-operation aborts with no o_done.
- States: IDLE, RUN, DONE.
- IDLE:
  - i_start=1 with i_len!=0: capture base and length, load o_mem_addr=i_base_addr, go to RUN, o_busy=1 next cycle.
  - i_start=1 with i_len=0: go to DONE with no reads and no stream words. The o_done pulse therefore occurs 1 cycle after the start cycle; o_busy stays 0.
- RUN issue rule:
  - A read is issued in a cycle when issued_cnt < len and (fifo_count + rd_pending + 1) <= 4.
  - rd_pending = read issued in the previous cycle whose data arrives this cycle.
  - On issue: o_mem_addr increments at the clock edge, modulo 2**ADDR_WIDTH, so it wraps from 2**ADDR_WIDTH-1 to 0.
  - On issue, rd_pending=1 next cycle.
- RUN receive rule:
  - When rd_pending=1, i_mem_dout is pushed into the FIFO at that edge.
  - The credit rule guarantees the FIFO never overflows. A push and a pop in the same cycle are both allowed.
- Stream side:
  - o_tvalid = FIFO not empty; o_tdata = FIFO head, registered.
  - A word transfers when o_tvalid and i_tready are both 1.
  - o_tdata and o_tvalid hold stable while o_tvalid=1 and i_tready=0.
- Latency: with the start accepted at edge E0, first o_mem_addr=base is valid after E0, first RAM data arrives after E1, and o_tvalid=1 after E2. o_tvalid therefore first rises in the 3rd cycle after the start cycle.
- Throughput: 1 word/cycle sustained while i_tready=1.
- Completion: when the len-th word is handshaken, go to DONE. In the next cycle o_done=1 and o_busy=0, then return to IDLE.
- i_start while not IDLE is ignored; the captured parameters are unchanged.
- Ordering: output order equals address order, including across the wrap.

Optional Feature:
- Macro: MEM_STREAM_READER_TLAST_EN.
- Defined: port o_tlast exists. It is 1 exactly when o_tvalid=1 and the head word is the len-th word of the run, and it is held through backpressure. It is tracked by tagging the FIFO entry at push time.
- Undefined: port o_tlast and its FIFO tag bit are absent; all other behaviour is identical.

Test Plan:
- Preload mem[0..3]=0xA0..0xA3; start base=0, len=4, i_tready=1 -> words 0xA0..0xA3 on 4 consecutive cycles, first o_tvalid 3 cycles after start, o_done one cycle after the last handshake.
- Same preload; i_tready low for cycles 3-8, then high -> no loss or duplication; o_tdata=0xA0 held while stalled; RAM reads stop once the FIFO holds 4 words.
- ADDR_WIDTH=10, preload mem[1022]=0x11, mem[1023]=0x22, mem[0]=0x33; start base=1022, len=3 -> stream 0x11, 0x22, 0x33 (wrap-around).
- Start with len=0 -> no o_tvalid; o_done pulse 1 cycle after start; o_busy stays 0. Start asserted during an active run -> ignored, run completes unchanged.
- Reset asserted mid-run after 2 of 8 words -> next cycle all outputs 0 and no o_done; a new start base=0, len=2 then streams correctly.
- With MEM_STREAM_READER_TLAST_EN defined, len=3 with a stall on word 3 -> o_tlast=1 only on word 3, held during the stall.
